// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and parity-type constants for the UART transmitter
// Contents: state_t (IDLE, START, DATA, PARITY, STOP), PAR_EVEN / PAR_ODD
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if: producer-side handshake and per-frame configuration bundle
// Signals: P_DATA, Data_valid, Data_ready, PAR_EN, PAR_TYP, STOP2, Prescale
// Modports: master (producer), slave (transmitter)
interface uart_tx_cfg_if #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 8
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_valid;
   logic                  Data_ready;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic                  STOP2;
   logic [PRESCALE_W-1:0] Prescale;
   modport master (output P_DATA, Data_valid, PAR_EN, PAR_TYP, STOP2, Prescale, input Data_ready);
   modport slave  (input P_DATA, Data_valid, PAR_EN, PAR_TYP, STOP2, Prescale, output Data_ready);
endinterface

// File: rtl/uart_parity_calc.sv
// uart_parity_calc: combinational parity bit for one data word
// Ports: data (word), typ (PAR_EVEN/PAR_ODD), par (parity bit to transmit)
module uart_parity_calc
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  typ,
   output logic                  par
);
   assign par = (typ == PAR_ODD) ? ~(^data) : ^data;
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with one-frame holding register
// Ports: CLK, rst (sync, active-high), bus (slave side of uart_tx_cfg_if),
//        TX_OUT (registered serial line, idle high), busy (registered, frame on line),
//        frame_done (pulse in last cycle of last stop bit)
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 8
) (
   input  logic          CLK,
   input  logic          rst,
   uart_tx_cfg_if.slave  bus,
   output logic          TX_OUT,
   output logic          busy,
   output logic          frame_done
);
   localparam int IW = $clog2(DATA_WIDTH);
   state_t state, state_n;
   logic hold_full, hold_par_en, hold_par_typ, hold_stop2, hold_par;
   logic [DATA_WIDTH-1:0] hold_data, sh, sh_n;
   logic [PRESCALE_W-1:0] hold_pre, pre, cnt;
   logic par_en, par, stop2, stop_idx;
   logic [IW-1:0] bit_idx;
   logic accept, load, bit_end, last_data, last_stop, tx_n;

   uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
      .data (hold_data),
      .typ  (hold_par_typ),
      .par  (hold_par)
   );

   assign bus.Data_ready = ~hold_full;
   assign accept         = bus.Data_valid & ~hold_full;
   assign bit_end        = (cnt == pre - 1'b1);
   assign last_data      = bit_end & (bit_idx == IW'(DATA_WIDTH - 1));
   assign last_stop      = bit_end & (stop_idx == stop2);
   assign frame_done     = (state == STOP) & last_stop;
   // holding moves to the shift register when idle or right at the end of a frame
   assign load           = hold_full & ((state == IDLE) | frame_done);

   always_ff @(posedge CLK) begin
      if (rst) state <= IDLE;
      else state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = hold_full ? START : IDLE;
         START:   state_n = bit_end ? DATA : START;
         DATA:    state_n = last_data ? (par_en ? PARITY : STOP) : DATA;
         PARITY:  state_n = bit_end ? STOP : PARITY;
         STOP:    state_n = last_stop ? (hold_full ? START : IDLE) : STOP;
         default: state_n = IDLE;
      endcase
   end

   // line value is computed for the upcoming state so TX_OUT can be a plain register
   always_comb begin
      sh_n = load ? hold_data : ((state == DATA) && bit_end) ? sh >> 1 : sh;
      tx_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? sh_n[0] : (state_n == PARITY) ? par : 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         TX_OUT    <= 1'b1;
         busy      <= 1'b0;
         hold_full <= 1'b0;
         cnt       <= '0;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
         sh        <= '0;
         par       <= 1'b0;
         par_en    <= 1'b0;
         stop2     <= 1'b0;
         pre       <= '0;
      end else begin
         TX_OUT    <= tx_n;
         busy      <= (state_n != IDLE);
         hold_full <= accept | (hold_full & ~load);
         cnt       <= ((state == IDLE) || bit_end) ? '0 : cnt + 1'b1;
         bit_idx   <= (state == DATA) ? bit_idx + IW'(bit_end) : '0;
         stop_idx  <= (state == STOP) ? stop_idx ^ bit_end : 1'b0;
         sh        <= sh_n;
         if (load) begin
            par    <= hold_par;
            par_en <= hold_par_en;
            stop2  <= hold_stop2;
            pre    <= hold_pre;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (accept) begin
         hold_data    <= bus.P_DATA;
         hold_par_en  <= bus.PAR_EN;
         hold_par_typ <= bus.PAR_TYP;
         hold_stop2   <= bus.STOP2;
         hold_pre     <= (bus.Prescale == '0) ? PRESCALE_W'(1) : bus.Prescale;
      end
   end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed self-checking bench for uart_tx_cfg (8-bit and 5-bit instances)
module tb_uart_tx_cfg;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx8, busy8, done8, tx5, busy5, done5;
   int total = 0;
   int bad = 0;

   uart_tx_cfg_if #(.DATA_WIDTH(8), .PRESCALE_W(8)) bus8 ();
   uart_tx_cfg_if #(.DATA_WIDTH(5), .PRESCALE_W(8)) bus5 ();

   uart_tx_cfg #(.DATA_WIDTH(8), .PRESCALE_W(8)) dut8 (
      .CLK(clk), .rst(rst), .bus(bus8), .TX_OUT(tx8), .busy(busy8), .frame_done(done8)
   );
   uart_tx_cfg #(.DATA_WIDTH(5), .PRESCALE_W(8)) dut5 (
      .CLK(clk), .rst(rst), .bus(bus5), .TX_OUT(tx5), .busy(busy5), .frame_done(done5)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input bit w5, input logic [8:0] d, input logic pen, input logic typ,
                        input logic s2, input logic [7:0] pre, input logic v);
      if (w5) begin
         bus5.P_DATA = d[4:0]; bus5.PAR_EN = pen; bus5.PAR_TYP = typ;
         bus5.STOP2 = s2; bus5.Prescale = pre; bus5.Data_valid = v;
      end else begin
         bus8.P_DATA = d[7:0]; bus8.PAR_EN = pen; bus8.PAR_TYP = typ;
         bus8.STOP2 = s2; bus8.Prescale = pre; bus8.Data_valid = v;
      end
   endtask

   // {ready, frame_done, busy, tx}
   function automatic logic [3:0] obs(input bit w5);
      return w5 ? {bus5.Data_ready, done5, busy5, tx5} : {bus8.Data_ready, done8, busy8, tx8};
   endfunction

   task automatic frame(input string name, input bit w5, input logic [8:0] d, input logic pen,
                        input logic typ, input logic s2, input logic [7:0] pre,
                        input logic [15:0] bits, input int nbits);
      int per = (pre == 8'd0) ? 1 : int'(pre);
      logic [3:0] s;
      @(negedge clk);
      drive(w5, d, pen, typ, s2, pre, 1'b1);
      s = obs(w5);
      chk({name, "_rdy_before"}, s[3], 1);
      @(posedge clk);
      #1;
      drive(w5, ~d, ~pen, ~typ, ~s2, pre + 8'd3, 1'b0);
      @(negedge clk);
      s = obs(w5);
      chk({name, "_lat_tx"}, s[0], 1);
      chk({name, "_rdy_full"}, s[3], 0);
      for (int b = 0; b < nbits; b++) begin
         for (int c = 0; c < per; c++) begin
            @(negedge clk);
            s = obs(w5);
            chk($sformatf("%s_tx_b%0d_c%0d", name, b, c), s[0], bits[b]);
            chk($sformatf("%s_busy_b%0d", name, b), s[1], 1);
            chk($sformatf("%s_done_b%0d_c%0d", name, b, c), s[2], (b == nbits - 1 && c == per - 1) ? 1 : 0);
         end
      end
      @(negedge clk);
      s = obs(w5);
      chk({name, "_idle_tx"}, s[0], 1);
      chk({name, "_idle_busy"}, s[1], 0);
      chk({name, "_idle_rdy"}, s[3], 1);
   endtask

   initial begin
      logic [19:0] b2b;
      drive(1'b0, 9'h0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0);
      drive(1'b1, 9'h0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tx8", tx8, 1);
      chk("rst_busy8", busy8, 0);
      chk("rst_done8", done8, 0);
      chk("rst_rdy8", bus8.Data_ready, 1);
      chk("rst_tx5", tx5, 1);
      chk("rst_rdy5", bus5.Data_ready, 1);
      rst = 1'b0;

      // 0xD5 no parity, 1 stop, 1 clock per bit
      frame("d5", 1'b0, 9'hD5, 1'b0, 1'b0, 1'b0, 8'd1, 16'b11_1010_1010, 10);
      // 0x01 even parity -> parity bit 1, 4 clocks per bit
      frame("p01", 1'b0, 9'h01, 1'b1, 1'b0, 1'b0, 8'd4, 16'b110_0000_0010, 11);
      // 0x03 odd parity -> parity bit 1, two stop bits, 12 periods
      frame("o03", 1'b0, 9'h03, 1'b1, 1'b1, 1'b1, 8'd2, 16'b1110_0000_0110, 12);
      // 5-bit 0x16, Prescale 0 acts as 1
      frame("w5", 1'b1, 9'h16, 1'b0, 1'b0, 1'b0, 8'd0, 16'b110_1100, 7);

      // back-to-back 0x55 then 0xA3 with Data_valid held high
      b2b = 20'b1101000110_1010101010;
      @(negedge clk);
      drive(1'b0, 9'h55, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1);
      @(posedge clk);
      #1 bus8.P_DATA = 8'hA3;
      @(negedge clk);
      chk("b2b_lat_tx", tx8, 1);
      chk("b2b_rdy_full", bus8.Data_ready, 0);
      for (int k = 0; k <= 20; k++) begin
         if (k == 1) begin
            @(posedge clk);
            #1 bus8.Data_valid = 1'b0;
         end
         @(negedge clk);
         if (k < 20) begin
            chk($sformatf("b2b_tx_%0d", k), tx8, b2b[k]);
            chk($sformatf("b2b_busy_%0d", k), busy8, 1);
            chk($sformatf("b2b_rdy_%0d", k), bus8.Data_ready, (k == 0 || k >= 10) ? 1 : 0);
            chk($sformatf("b2b_done_%0d", k), done8, (k == 9 || k == 19) ? 1 : 0);
         end else begin
            chk("b2b_end_tx", tx8, 1);
            chk("b2b_end_busy", busy8, 0);
         end
      end

      // reset in DATA with a second frame pending in holding
      @(negedge clk);
      drive(1'b0, 9'h00, 1'b0, 1'b0, 1'b0, 8'd4, 1'b1);
      repeat (3) @(posedge clk);
      #1 bus8.Data_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("mid_tx", tx8, 0);
      chk("mid_busy", busy8, 1);
      chk("mid_rdy", bus8.Data_ready, 0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_tx", tx8, 1);
      chk("abort_busy", busy8, 0);
      chk("abort_rdy", bus8.Data_ready, 1);
      chk("abort_done", done8, 0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk($sformatf("abort_quiet_tx_%0d", k), tx8, 1);
         chk($sformatf("abort_quiet_busy_%0d", k), busy8, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
